// File: rtl/store_pkg.sv
// Shared store-path definitions: size codes, aligner FSM states and
// the byte-count mask for a size code.
package store_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    BEAT1,
    BEAT2
  } state_e;

  function automatic logic [7:0] lane_mask(input logic [1:0] size);
    logic [7:0] m;
    unique case (size)
      SZ_BYTE: m = 8'h01;
      SZ_HALF: m = 8'h03;
      SZ_WORD: m = 8'h0F;
      SZ_DWORD: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane generator: byte enables and shifted data over a
// two-word span, plus word-crossing, misalignment and oversize flags.
module store_lane_gen
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [OW-1:0]       off_i,
  input  logic [1:0]          size_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic [2*NB-1:0]     be_o,
  output logic [2*DATA_W-1:0] wd_o,
  output logic                cross_o,
  output logic                misalign_o,
  output logic                too_big_o
);

  localparam int SW = 2 * NB;

  logic [3:0]          n;
  logic [SW-1:0]       m;
  logic [2*DATA_W-1:0] ds;

  always_comb begin
    n    = 4'd1 << size_i;
    m    = SW'(lane_mask(size_i));
    be_o = m << off_i;
    ds   = {{DATA_W{1'b0}}, data_i} << {off_i, 3'b000};
    wd_o = '0;
    // Bytes outside the enabled lanes are forced to zero
    for (int i = 0; i < SW; i++) begin
      wd_o[8*i +: 8] = be_o[i] ? ds[8*i +: 8] : 8'h00;
    end
    cross_o    = (int'(off_i) + int'(n)) > NB;
    too_big_o  = int'(n) > NB;
    misalign_o = |(off_i & OW'(n - 4'd1));
  end

endmodule

// File: rtl/store_lane_aligner.sv
// Store-path aligner, MEM stage to data-memory write port, one register stage.
// STORE_MISALIGN_SPLIT_EN: allow any offset, splitting word-crossing stores in two beats.
module store_lane_aligner
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [1:0]          in_size,
  input  logic [DATA_W-1:0]   in_data,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic                bus_last,
  output logic                err_valid,
  output logic [ADDR_W-1:0]   err_addr
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);

  logic [2*NB-1:0]     gen_be;
  logic [2*DATA_W-1:0] gen_wd;
  logic                gen_cross;
  logic                gen_mis;
  logic                gen_big;

  store_lane_gen #(.DATA_W(DATA_W)) u_gen (
    .off_i      (in_addr[OW-1:0]),
    .size_i     (in_size),
    .data_i     (in_data),
    .be_o       (gen_be),
    .wd_o       (gen_wd),
    .cross_o    (gen_cross),
    .misalign_o (gen_mis),
    .too_big_o  (gen_big)
  );

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NB-1:0]     be_q, be_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              errv_q, errv_d;
  logic [ADDR_W-1:0] erra_q, erra_d;
  logic              reject;
  logic              accept;
  logic              retire;

`ifdef STORE_MISALIGN_SPLIT_EN
  logic [NB-1:0]     hbe_q, hbe_d;
  logic [DATA_W-1:0] hwd_q, hwd_d;
  logic              unused_mis;

  assign unused_mis = gen_mis;
  assign reject     = gen_big;
`else
  logic unused_hi;

  assign unused_hi = ^{gen_be[2*NB-1:NB], gen_wd[2*DATA_W-1:DATA_W], gen_cross};
  assign reject    = gen_big | gen_mis;
`endif

  assign retire   = valid_q & bus_ready & last_q;
  assign in_ready = (state_q == IDLE) | retire;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    last_d  = last_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    errv_d  = 1'b0;
    erra_d  = erra_q;
`ifdef STORE_MISALIGN_SPLIT_EN
    hbe_d   = hbe_q;
    hwd_d   = hwd_q;
`endif
    unique case (state_q)
      IDLE: ;
      BEAT1: begin
        if (valid_q & bus_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
`ifdef STORE_MISALIGN_SPLIT_EN
          else begin
            state_d = BEAT2;
            addr_d  = addr_q + ADDR_W'(NB);
            be_d    = hbe_q;
            wd_d    = hwd_q;
            last_d  = 1'b1;
          end
`endif
        end
      end
`ifdef STORE_MISALIGN_SPLIT_EN
      BEAT2: begin
        if (valid_q & bus_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // A new request overrides the retiring beat in the same cycle
    if (accept) begin
      if (reject) begin
        errv_d = 1'b1;
        erra_d = in_addr;
      end else begin
        state_d = BEAT1;
        valid_d = 1'b1;
        addr_d  = in_addr & ~ADDR_W'(NB - 1);
        be_d    = gen_be[NB-1:0];
        wd_d    = gen_wd[DATA_W-1:0];
`ifdef STORE_MISALIGN_SPLIT_EN
        last_d  = ~gen_cross;
        hbe_d   = gen_be[2*NB-1:NB];
        hwd_d   = gen_wd[2*DATA_W-1:DATA_W];
`else
        last_d  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      errv_q  <= 1'b0;
      erra_q  <= '0;
`ifdef STORE_MISALIGN_SPLIT_EN
      hbe_q   <= '0;
      hwd_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      errv_q  <= errv_d;
      erra_q  <= erra_d;
`ifdef STORE_MISALIGN_SPLIT_EN
      hbe_q   <= hbe_d;
      hwd_q   <= hwd_d;
`endif
    end
  end

  assign bus_valid = valid_q;
  assign bus_last  = last_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wd_q;
  assign err_valid = errv_q;
  assign err_addr  = erra_q;

endmodule

// File: tb/tb_store_lane_aligner.sv
// Self-checking bench for store_lane_aligner: directed cases plus random
// stores against a byte-level reference model.
module tb_store_lane_aligner;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int NB = DATA_W / 8;
`ifdef STORE_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [1:0]        in_size;
  logic [DATA_W-1:0] in_data;
  logic              bus_valid;
  logic              bus_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic [NB-1:0]     bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_last;
  logic              err_valid;
  logic [ADDR_W-1:0] err_addr;

  store_lane_aligner #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_size   (in_size),
    .in_data   (in_data),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_last  (bus_last),
    .err_valid (err_valid),
    .err_addr  (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  bit          exp_err;
  int          exp_nb;
  logic [NB-1:0] exp_be[2];
  logic [31:0] exp_wd[2];
  logic [31:0] exp_addr[2];
  logic [31:0] bb[4];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Place each stored byte at address a+k into its word and lane
  task automatic model(input logic [31:0] a, input logic [1:0] sz,
                       input logic [63:0] d);
    int n, off, pos;
    n = 1 << sz;
    off = int'(a % NB);
    exp_err = (n > NB) || (!SPLIT && (off % n) != 0);
    exp_nb = (off + n > NB) ? 2 : 1;
    for (int b = 0; b < 2; b++) begin
      exp_be[b] = '0;
      exp_wd[b] = '0;
    end
    exp_addr[0] = a - off;
    exp_addr[1] = a - off + NB;
    if (!exp_err) begin
      for (int k = 0; k < n; k++) begin
        pos = off + k;
        exp_be[pos / NB][pos % NB] = 1'b1;
        exp_wd[pos / NB][8*(pos % NB) +: 8] = d[8*k +: 8];
      end
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [1:0] sz,
                      input logic [63:0] d, input int stall);
    int s;
    model(a, sz, d);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_addr = a;
    in_size = sz;
    in_data = d[31:0];
    bus_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    if (exp_err) begin
      chk("err_valid", err_valid, 1);
      chk("err_addr", err_addr, a);
      chk("err_no_beat", bus_valid, 0);
      @(negedge clk);
      chk("err_pulse_end", err_valid, 0);
      chk("err_no_beat2", bus_valid, 0);
    end else begin
      for (int b = 0; b < exp_nb; b++) begin
        s = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
        for (int c = 0; c <= s; c++) begin
          chk("bus_valid", bus_valid, 1);
          chk("bus_addr", bus_addr, exp_addr[b]);
          chk("bus_be", bus_be, exp_be[b]);
          chk("bus_wdata", bus_wdata, exp_wd[b]);
          chk("bus_last", bus_last, b == exp_nb - 1);
          bus_ready = (c == s);
          #1;
          chk("in_ready_beat", in_ready, bus_ready && (b == exp_nb - 1));
          @(negedge clk);
        end
      end
      bus_ready = 1'b0;
      chk("idle_after", bus_valid, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_addr = '0;
    in_size = '0;
    in_data = '0;
    bus_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", bus_valid, 0);
    chk("rst_last", bus_last, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    send(32'h0000_1003, 2'd0, 64'hAB, 0);
    send(32'h0000_2002, 2'd1, 64'hBEEF, 3);
    send(32'h0000_3003, 2'd2, 64'h1122_3344, 0);
    send(32'h0000_4001, 2'd1, 64'h5566, 0);
    send(32'h0000_4000, 2'd3, 64'h0102_0304_0506_0708, 0);
    send(32'hFFFF_FFFF, 2'd1, 64'hCAFE, 1);
    send(32'h0000_7004, 2'd2, 64'hDEAD_BEEF, 2);

    for (int i = 0; i < 4; i++) bb[i] = $urandom;
    bus_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_in_ready", in_ready, 1);
      if (i > 0) begin
        chk("b2b_valid", bus_valid, 1);
        chk("b2b_wdata", bus_wdata, bb[i-1]);
        chk("b2b_be", bus_be, 4'hF);
      end
      in_valid = 1'b1;
      in_addr = 32'h0000_6000 + 32'(4 * i);
      in_size = 2'd2;
      in_data = bb[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_valid_last", bus_valid, 1);
    chk("b2b_wdata_last", bus_wdata, bb[3]);
    @(negedge clk);
    chk("b2b_drain", bus_valid, 0);
    bus_ready = 1'b0;

    for (int i = 0; i < 40; i++) begin
      send($urandom, 2'($urandom_range(0, 3)), {$urandom, $urandom}, -1);
    end

    in_valid = 1'b1;
`ifdef STORE_MISALIGN_SPLIT_EN
    in_addr = 32'h0000_5003;
`else
    in_addr = 32'h0000_5000;
`endif
    in_size = 2'd2;
    in_data = 32'h99AA_BBCC;
    bus_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_pre_valid", bus_valid, 1);
`ifdef STORE_MISALIGN_SPLIT_EN
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    chk("rst_in_beat2", bus_last, 1);
`endif
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", bus_valid, 0);
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_be", bus_be, 0);
    reset = 1'b0;
    bus_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_replay", bus_valid, 0);
    end
    chk("rst_err_addr_clr", err_addr, 0);
    bus_ready = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
